// File: rtl/soc_mem_pkg.sv
// Shared memory-subsystem types and constants.
//   ADDR_W / DATA_W / MASK_W : byte address, data word and byte-enable widths
//   WADDR_W                  : word address width (byte address without bits [1:0])
//   sb_entry_t               : one buffered store {word addr, data, byte mask}
//   port_sel_e               : owner of the shared dcache port in a given cycle
//   ptr_inc()                : circular pointer increment with wrap at depth
package soc_mem_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MASK_W  = DATA_W / 8;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
        logic [MASK_W-1:0]  mask;
    } sb_entry_t;

    typedef enum logic [1:0] {
        PortIdle,
        PortLoad,
        PortDrain
    } port_sel_e;

    function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
        return (ptr + 32'd1 == depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Byte-wise store-to-load forwarding for the store buffer (purely combinational).
//   entries     : buffered store array
//   valid       : per-slot pending flag
//   rd_ptr      : slot of the oldest pending store
//   ld_waddr    : word address of the load
//   cache_rdata : data returned by the dcache for the load
//   merged      : cache data with each byte overridden by the youngest matching store
module sb_fwd_merge
    import soc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   rd_ptr,
    input  logic [WADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0]  cache_rdata,
    output logic [DATA_W-1:0]  merged
);

    // Walk from oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        merged = cache_rdata;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr + PTR_W'(k);
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (valid[idx] && (entries[idx].addr == ld_waddr) && entries[idx].mask[b]) begin
                    merged[8*b +: 8] = entries[idx].data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and the dcache.
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   core_wr_req/rd_req: core store / load requests sharing core_addr
//   core_wdata/mask   : store data and byte enables
//   core_rdata        : load data, cache data merged with pending stores
//   stall             : store refused because the buffer is full
//   sb_empty          : no pending stores (fence)
//   cache_*           : single dcache port; loads win, otherwise the head store drains
module dmem_store_buffer
    import soc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wr_req,
    input  logic              core_rd_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [MASK_W-1:0] core_wr_mask,
    output logic [DATA_W-1:0] core_rdata,
    output logic              stall,
    output logic              sb_empty,
    output logic              cache_wr_req,
    output logic [MASK_W-1:0] cache_wr_mask,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic [DATA_W-1:0] cache_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          entries_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid;
    logic               full;
    logic               push;
    logic               pop;
    port_sel_e          port_sel;
    sb_entry_t          head;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign stall    = core_wr_req && full;
    // A full buffer refuses the store even if the head drains this cycle.
    assign push     = core_wr_req && !full;
    assign pop      = (port_sel == PortDrain);
    assign head     = entries_q[rd_ptr_q];

    // Slot i is pending when its distance from rd_ptr is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        valid  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset   = PTR_W'(i) - rd_ptr_q;
            valid[i] = (CNT_W'(offset) < count_q);
        end
    end

    always_comb begin
        if (core_rd_req) begin
            port_sel = PortLoad;
        end else if (!sb_empty) begin
            port_sel = PortDrain;
        end else begin
            port_sel = PortIdle;
        end
    end

    always_comb begin
        cache_wr_req  = 1'b0;
        cache_addr    = core_addr;
        cache_wdata   = '0;
        cache_wr_mask = '0;
        unique case (port_sel)
            PortDrain: begin
                cache_wr_req  = 1'b1;
                cache_addr    = {head.addr, 2'b00};
                cache_wdata   = head.data;
                cache_wr_mask = head.mask;
            end
            PortLoad, PortIdle: begin
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = pop  ? PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: valid is derived from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{addr: core_addr[ADDR_W-1:2],
                                     data: core_wdata,
                                     mask: core_wr_mask};
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .entries     (entries_q),
        .valid       (valid),
        .rd_ptr      (rd_ptr_q),
        .ld_waddr    (core_addr[ADDR_W-1:2]),
        .cache_rdata (cache_rdata),
        .merged      (core_rdata)
    );

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write buffer between the processor's data-memory port and the data cache.
- Stores are accepted in one cycle and queued in a small FIFO. They drain to the cache one per cycle whenever the core is not using the cache port for a load.
- Loads read the cache directly, with byte-wise forwarding from pending stores so program order is preserved.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width; MASK_W = DATA_W/8.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- core_wr_req  in  1  core store request.
- core_rd_req  in  1  core load request.
- core_addr  in  ADDR_W  core byte address; bits [1:0] ignored, word-aligned.
- core_wdata  in  DATA_W  store data.
- core_wr_mask  in  MASK_W  store byte enables; bit i = byte i.
- core_rdata  out  DATA_W  load data, cache data merged with forwarded bytes.
- stall  out  1  store not accepted this cycle; core must hold the request.
- sb_empty  out  1  no pending stores; used for fence.
- cache_wr_req  out  1  write strobe to dcache.
- cache_wr_mask  out  MASK_W  byte enables to dcache.
- cache_addr  out  ADDR_W  dcache address.
- cache_wdata  out  DATA_W  dcache write data.
- cache_rdata  in  DATA_W  dcache read data, combinational from cache_addr.

Behaviour:
- Storage: DEPTH entries of {word addr [ADDR_W-1:2], data, mask}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is 0..DEPTH.
- full = (count == DEPTH); sb_empty = (count == 0).
- Enqueue at clk edge when core_wr_req && !full.
- stall = core_wr_req && full, combinational. No enqueue-when-full, even if a pop occurs in the same cycle.
- Port mux (combinational):
  - If core_rd_req: cache_addr = core_addr, cache_wr_req = 0.
  - Else if !sb_empty: cache_addr = {head.addr, 2'b00}, cache_wdata = head.data, cache_wr_mask = head.mask, cache_wr_req = 1; pop at the edge.
  - Else: cache_wr_req = 0, cache_addr = core_addr, cache_wr_mask = 0.
- Simultaneous enqueue and pop: both happen and count is unchanged.
- Simultaneous core_wr_req and core_rd_req: both are serviced. The same-cycle store is not forwarded to that load.
- Latency: a store enqueued at edge N gives cache_wr_req = 1 in cycle N+1 at the earliest, and is written at edge N+1. Each core_rd_req cycle delays draining by one cycle.
- Forwarding:
  - For each byte lane, core_rdata takes the byte from the youngest valid entry whose word address equals core_addr[ADDR_W-1:2] and whose mask bit is set.
  - If no entry matches, the byte comes from cache_rdata.
  - Age is ordered from rd_ptr toward wr_ptr.
  - core_rdata is don't-care when core_rd_req = 0, but must still be X-free.
- Reset (rst = 0, any time, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - All pending stores are discarded; entry payload need not be cleared.
  - Outputs: stall = 0, sb_empty = 1, cache_wr_req = 0, cache_wr_mask = 0.
- A mask of 4'b0000 is enqueued like any other store. It drains with no effect.

Decomposition:
- Package soc_mem_pkg holds:
  - ADDR_W, DATA_W, MASK_W constants.
  - typedef sb_entry_t {word addr, data, mask}.
  - Function for ptr increment with wrap.
- Sub-module sb_fwd_merge (combinational): takes the entry array, valid vector, rd_ptr, load word address and cache_rdata; outputs the merged word.
- FIFO control stays in the top module.

Test Plan:
- Single store then drain: wr 0x100 = 0xDEADBEEF, mask 4'hF.
  - Expect cache_wr_req = 1 with addr 0x100 in the next cycle.
  - Expect sb_empty = 1 the cycle after that.
  - A later load of 0x100 returns 0xDEADBEEF.
- Fill and stall (DEPTH = 4):
  - Hold core_rd_req = 1 and issue 5 stores: 4 accepted, 5th sees stall = 1.
  - Drop rd_req: the 5th is accepted the cycle after the first pop. Drain order matches issue order.
- Forwarding with partial masks:
  - Cache word at 0x200 = 0x11223344. Buffered stores to 0x200: 0xAA000000 mask 4'h8, then 0x0000BB00 mask 4'h2.
  - With rd_req held: load 0x200 returns 0xAA22BB44.
  - Then a third store 0xCC000000 mask 4'h8: load returns 0xCC22BB44 (youngest wins).
- Load priority over drain:
  - 2 pending stores with core_rd_req high for 3 cycles: cache_wr_req = 0 throughout.
  - Drains complete in the 2 cycles after rd_req falls.
- Simultaneous enqueue and pop at count = 2: count stays 2. Pointer wrap over 10 stores keeps FIFO order.
- Async reset mid-drain with 3 pending stores:
  - Assert rst = 0 between edges: sb_empty = 1 and cache_wr_req = 0 immediately.
  - No further cache writes after release.
